// File: rtl/debounce_enable_gen_if.sv
// Signal bundle between the debounce/enable generator and its consumer.
// With DEBOUNCE_GLITCH_CNT_EN defined the bundle also carries glitch_cnt.
interface debounce_enable_gen_if;
  logic       raw_in;
  logic       hold;
  logic       d;
  logic       enable;
  logic       rise;
  logic       fall;
  logic       busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;

  modport master (output raw_in, hold, input d, enable, rise, fall, busy, glitch_cnt);
  modport slave  (input raw_in, hold, output d, enable, rise, fall, busy, glitch_cnt);
`else
  modport master (output raw_in, hold, input d, enable, rise, fall, busy);
  modport slave  (input raw_in, hold, output d, enable, rise, fall, busy);
`endif
endinterface

// File: rtl/debounce_enable_gen.sv
// Synchronizes and debounces a raw level, then drives a downstream
// register's D with the clean level and ENABLE with a one-cycle load strobe.
// Optional macro DEBOUNCE_GLITCH_CNT_EN adds a saturating 8-bit abort counter.
//
//   state | meaning
//   IDLE  | synchronized input agrees with committed level
//   COUNT | mismatch seen, counting consecutive mismatching edges
//   PEND  | mismatch qualified, commit deferred while hold is high
module debounce_enable_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  debounce_enable_gen_if.slave bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COUNT, PEND} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   d_q, d_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   commit;
  logic                   abort;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain on the asynchronous raw input.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) sync_q <= '0;
    else            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.raw_in};
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      count_q <= '0;
      d_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      d_q     <= d_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state, counter and commit decode.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    commit  = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s != d_q) begin
          state_d = COUNT;
          count_d = CW'(1);
        end else begin
          count_d = '0;
        end
      end
      COUNT: begin
        if (s == d_q) begin
          state_d = IDLE;
          count_d = '0;
          abort   = 1'b1;
        end else if (count_q != CNT_LAST) begin
          count_d = count_q + CW'(1);
        end else if (!bus.hold) begin
          commit  = 1'b1;
        end else begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (s == d_q) begin
          state_d = IDLE;
          count_d = '0;
          abort   = 1'b1;
        end else if (!bus.hold) begin
          commit  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    if (commit) begin
      state_d = IDLE;
      count_d = '0;
    end
    d_d    = commit ? s : d_q;
    rise_d = commit & s;
    fall_d = commit & ~s;
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_q;

  // Saturating count of aborted (rejected) changes.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)                      glitch_q <= '0;
    else if (abort && glitch_q != 8'hFF) glitch_q <= glitch_q + 8'd1;
  end

  assign bus.glitch_cnt = glitch_q;
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

  assign bus.d      = d_q;
  assign bus.rise   = rise_q;
  assign bus.fall   = fall_q;
  // Deriving the strobe from rise/fall keeps ENABLE == RISE|FALL by construction.
  assign bus.enable = rise_q | fall_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_debounce_enable_gen.sv
// Self-checking bench for debounce_enable_gen (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// The reference model tracks the run length of consecutive edges on which the
// synchronized input differs from the committed level.
module tb_debounce_enable_gen;
  localparam int SYNC = 2;
  localparam int DC   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  debounce_enable_gen_if bus ();

  debounce_enable_gen #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic m_sync [SYNC];
  logic m_d, m_rise, m_fall;
  int   m_run, m_glitch;

  task automatic model_edge(input logic r, input logic h, input logic rn);
    logic s;
    if (!rn) begin
      for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
      m_d = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_glitch = 0;
    end else begin
      s = m_sync[SYNC-1];
      m_rise = 1'b0; m_fall = 1'b0;
      if (s == m_d) begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end else begin
        m_run++;
        if (m_run >= DC && !h) begin
          m_d = s; m_rise = s; m_fall = !s; m_run = 0;
        end
      end
      for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = r;
    end
  endtask

  function automatic logic [4:0] exp_vec();
    return {m_d, m_rise | m_fall, m_rise, m_fall, (m_run > 0)};
  endfunction

  function automatic logic [4:0] obs_vec();
    return {bus.d, bus.enable, bus.rise, bus.fall, bus.busy};
  endfunction

  task automatic tick(input logic r, input logic h, input logic rn);
    @(negedge clk);
    bus.raw_in = r; bus.hold = h; rst_n = rn;
    @(posedge clk);
    model_edge(r, h, rn);
    #1;
  endtask

  task automatic test_reset();
    int en_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== 5'b0) begin
        errors++;
        $display("FAIL reset_state cycle %0d: got %b want 00000", i, obs_vec());
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      en_cnt += int'(bus.enable);
      checks++;
      if (bus.enable !== (i == 5) || bus.d !== (i >= 5) || bus.rise !== (i == 5)) begin
        errors++;
        $display("FAIL reset_latency edge R0+%0d: got d=%b en=%b rise=%b want d=%b en=%b rise=%b",
                 i, bus.d, bus.enable, bus.rise, (i >= 5), (i == 5), (i == 5));
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_model edge %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (en_cnt != 1) begin
      errors++;
      $display("FAIL reset_strobe_count: got %0d want 1", en_cnt);
    end
  endtask

  task automatic test_glitch();
    int en_cnt = 0;
    bit busy_seen = 0;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick((i < 3), 1'b0, 1'b1);
      en_cnt += int'(bus.enable);
      if (bus.busy) busy_seen = 1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_model cycle %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (en_cnt != 0 || bus.d !== 1'b0 || !busy_seen || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject: got en_cnt=%0d d=%b busy_seen=%0d busy=%b want 0 0 1 0",
               en_cnt, bus.d, busy_seen, bus.busy);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (bus.glitch_cnt !== 8'd1) begin
      errors++;
      $display("FAIL glitch_cnt: got %0d want 1", bus.glitch_cnt);
    end
`endif
  endtask

  task automatic test_fall();
    int en_cnt = 0;
    int fall_cnt = 0;
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.d !== 1'b1) begin
      errors++;
      $display("FAIL fall_precondition d: got %b want 1", bus.d);
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      en_cnt += int'(bus.enable);
      fall_cnt += int'(bus.fall);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fall_model cycle %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (en_cnt != 1 || fall_cnt != 1 || bus.d !== 1'b0) begin
      errors++;
      $display("FAIL fall_strobe: got en=%0d fall=%0d d=%b want 1 1 0", en_cnt, fall_cnt, bus.d);
    end
  endtask

  task automatic test_hold();
    int en_cnt = 0;
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      en_cnt += int'(bus.enable);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL hold_model cycle %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (en_cnt != 0 || bus.busy !== 1'b1 || bus.d !== 1'b0) begin
      errors++;
      $display("FAIL hold_pending: got en=%0d busy=%b d=%b want 0 1 0", en_cnt, bus.busy, bus.d);
    end
    tick(1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.enable !== 1'b1 || bus.d !== 1'b1 || bus.rise !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got en=%b d=%b rise=%b want 1 1 1", bus.enable, bus.d, bus.rise);
    end
    // Raw level reverts while pending
    en_cnt = 0;
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick((i < 10), (i < 16), 1'b1);
      en_cnt += int'(bus.enable);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL hold_abort_model cycle %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (en_cnt != 0 || bus.d !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_abort: got en=%0d d=%b busy=%b want 0 0 0", en_cnt, bus.d, bus.busy);
    end
  endtask

  task automatic test_mid_reset();
    int en_cnt = 0;
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_precondition busy: got %b want 1", bus.busy);
    end
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== 5'b0) begin
      errors++;
      $display("FAIL midreset_state: got %b want 00000", obs_vec());
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      en_cnt += int'(bus.enable);
    end
    checks++;
    if (en_cnt != 0 || bus.d !== 1'b0) begin
      errors++;
      $display("FAIL midreset_nostrobe: got en=%0d d=%b want 0 0", en_cnt, bus.d);
    end
  endtask

  task automatic test_toggle();
    int en_cnt = 0;
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick(i[0], 1'b0, 1'b1);
      en_cnt += int'(bus.enable);
    end
    checks++;
    if (en_cnt != 0 || bus.d !== 1'b0) begin
      errors++;
      $display("FAIL toggle_nocommit: got en=%0d d=%b want 0 0", en_cnt, bus.d);
    end
  endtask

  task automatic test_random();
    logic r = 1'b0;
    logic h = 1'b0;
    int   run_left = 0;
    int   strobes = 0;
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        r = $urandom_range(1, 0) != 0;
        run_left = $urandom_range(9, 1);
      end
      run_left--;
      if ($urandom_range(9, 0) == 0) h = ~h;
      tick(r, h, ($urandom_range(499, 0) != 0));
      strobes += int'(bus.enable);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_model cycle %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      checks++;
      if (bus.glitch_cnt !== 8'(m_glitch)) begin
        errors++;
        $display("FAIL random_glitch cycle %0d: got %0d want %0d", i, bus.glitch_cnt, m_glitch);
      end
`endif
    end
    checks++;
    if (strobes == 0) begin
      errors++;
      $display("FAIL random_activity: got 0 strobes want >0");
    end
  endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
  task automatic test_saturation();
    tick(1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 300; g++) begin
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b1);
    end
    checks++;
    if (bus.glitch_cnt !== 8'd255 || m_glitch != 255) begin
      errors++;
      $display("FAIL glitch_saturation: got %0d want 255", bus.glitch_cnt);
    end
  endtask
`endif

  initial begin
    bus.raw_in = 1'b0;
    bus.hold   = 1'b0;
    for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
    m_d = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_glitch = 0;
    test_reset();
    test_glitch();
    test_fall();
    test_hold();
    test_mid_reset();
    test_toggle();
    test_random();
`ifdef DEBOUNCE_GLITCH_CNT_EN
    test_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
